// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front end of the single-issue MIPS core. It holds the PC and requests one
// instruction word at a time from instruction memory. It latches the returned
// word and presents it, with its OP field, to the control decoder and the
// datapath. When the datapath consumes the instruction, the unit resolves
// BEQ/BNE and moves the PC either to the next word or to the branch target.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   InstrValid    in   memory returns InstrData this cycle
//   InstrData     in   instruction word from memory
//   Consume       in   datapath accepts the presented instruction
//   BranchEQ      in   current instruction is BEQ
//   BranchNE      in   current instruction is BNE
//   Zero          in   ALU zero flag for the current instruction
//   BranchOffset  in   sign-extended 16-bit immediate
//   InstrReq      out  read request to instruction memory
//   InstrAddr     out  word address of the request (= PC)
//   Instruction   out  latched instruction
//   OP            out  Instruction[31:26]
//   InstrReady    out  Instruction/OP valid, awaiting Consume
//   PC            out  address of the presented instruction
//   PC_4          out  PC + 4
//   RetireCount   out  number of consumed instructions, wraps
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  InstrValid,
    input  logic [DATA_WIDTH-1:0] InstrData,
    input  logic                  Consume,
    input  logic                  BranchEQ,
    input  logic                  BranchNE,
    input  logic                  Zero,
    input  logic [DATA_WIDTH-1:0] BranchOffset,
    output logic                  InstrReq,
    output logic [DATA_WIDTH-1:0] InstrAddr,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic [5:0]            OP,
    output logic                  InstrReady,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PC_4,
    output logic [31:0]           RetireCount
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetchState_e;

    // Word alignment is applied to every PC load, including the reset value.
    localparam logic [DATA_WIDTH-1:0] PC_RESET_ALIGNED = {PC_RESET[DATA_WIDTH-1:2], 2'b00};

    fetchState_e           stateReg;
    fetchState_e           stateNext;
    logic [DATA_WIDTH-1:0] pcReg;
    logic [DATA_WIDTH-1:0] pcNext;
    logic [DATA_WIDTH-1:0] instrReg;
    logic [DATA_WIDTH-1:0] instrNext;
    logic [31:0]           retireReg;
    logic [31:0]           retireNext;

    logic [DATA_WIDTH-1:0] pcPlus4;
    logic [DATA_WIDTH-1:0] branchTarget;
    logic [DATA_WIDTH-1:0] pcTarget;
    logic                  branchTaken;

    // Sequential-PC and branch-target arithmetic; all sums wrap modulo
    // 2^DATA_WIDTH. The offset is a word offset, hence the shift by two.
    assign pcPlus4      = pcReg + DATA_WIDTH'(4);
    assign branchTarget = pcPlus4 + {BranchOffset[DATA_WIDTH-3:0], 2'b00};

    // BranchEQ and BranchNE are mutually exclusive from the decoder; if both
    // are ever set the formula simply yields "taken".
    assign branchTaken  = (BranchEQ & Zero) | (BranchNE & ~Zero);
    assign pcTarget     = branchTaken ? branchTarget : pcPlus4;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg  <= FETCH;
            pcReg     <= PC_RESET_ALIGNED;
            instrReg  <= '0;
            retireReg <= '0;
        end else begin
            stateReg  <= stateNext;
            pcReg     <= pcNext;
            instrReg  <= instrNext;
            retireReg <= retireNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        stateNext  = stateReg;
        pcNext     = pcReg;
        instrNext  = instrReg;
        retireNext = retireReg;

        unique case (stateReg)
            FETCH: begin
                // Consume is meaningless here: nothing is being presented.
                if (InstrValid) begin
                    instrNext = InstrData;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                // InstrValid is ignored here so a late or spurious memory
                // response cannot overwrite the presented instruction.
                if (Consume) begin
                    pcNext     = {pcTarget[DATA_WIDTH-1:2], 2'b00};
                    retireNext = retireReg + 32'd1;
                    stateNext  = FETCH;
                end
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The request is gated with reset directly so that an in-flight fetch is
    // abandoned the moment reset asserts, not at the next clock edge.
    assign InstrReq    = reset & (stateReg == FETCH);
    assign InstrReady  = (stateReg == ISSUE);
    assign InstrAddr   = pcReg;
    assign PC          = pcReg;
    assign PC_4        = pcPlus4;
    assign Instruction = instrReg;
    assign OP          = instrReg[DATA_WIDTH-1 -: 6];
    assign RetireCount = retireReg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed scenarios with literal expectations, followed by a randomized run.
// A behavioural model tracks what the fetch unit must present; a compare
// process checks every DUT output against it on each falling clock edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [31:0] PC_RESET = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        InstrValid;
    logic [31:0] InstrData;
    logic        Consume;
    logic        BranchEQ;
    logic        BranchNE;
    logic        Zero;
    logic [31:0] BranchOffset;
    logic        InstrReq;
    logic [31:0] InstrAddr;
    logic [31:0] Instruction;
    logic [5:0]  OP;
    logic        InstrReady;
    logic [31:0] PC;
    logic [31:0] PC_4;
    logic [31:0] RetireCount;

    instruction_fetch_unit #(
        .DATA_WIDTH (32),
        .PC_RESET   (PC_RESET)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .InstrValid   (InstrValid),
        .InstrData    (InstrData),
        .Consume      (Consume),
        .BranchEQ     (BranchEQ),
        .BranchNE     (BranchNE),
        .Zero         (Zero),
        .BranchOffset (BranchOffset),
        .InstrReq     (InstrReq),
        .InstrAddr    (InstrAddr),
        .Instruction  (Instruction),
        .OP           (OP),
        .InstrReady   (InstrReady),
        .PC           (PC),
        .PC_4         (PC_4),
        .RetireCount  (RetireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: "holding" means an instruction has been received
    // and is waiting to be consumed; otherwise the unit is asking for the
    // word at modelPc.
    // ------------------------------------------------------------------
    bit          holding;
    logic [31:0] modelPc;
    logic [31:0] modelInstr;
    logic [31:0] modelRetired;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            holding      <= 1'b0;
            modelPc      <= PC_RESET;
            modelInstr   <= 32'd0;
            modelRetired <= 32'd0;
        end else if (!holding) begin
            if (InstrValid) begin
                holding    <= 1'b1;
                modelInstr <= InstrData;
            end
        end else if (Consume) begin
            holding      <= 1'b0;
            modelRetired <= modelRetired + 32'd1;
            if ((BranchEQ && Zero) || (BranchNE && !Zero))
                modelPc <= (modelPc + 32'd4 + BranchOffset * 32'd4) & 32'hFFFF_FFFC;
            else
                modelPc <= (modelPc + 32'd4) & 32'hFFFF_FFFC;
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            chk("InstrReq",    {31'd0, InstrReq},   {31'd0, reset && !holding});
            chk("InstrReady",  {31'd0, InstrReady}, {31'd0, holding});
            chk("InstrAddr",   InstrAddr,           modelPc);
            chk("PC",          PC,                  modelPc);
            chk("PC_4",        PC_4,                modelPc + 32'd4);
            chk("Instruction", Instruction,         modelInstr);
            chk("OP",          {26'd0, OP},         {26'd0, modelInstr[31:26]});
            chk("RetireCount", RetireCount,         modelRetired);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic v, input logic [31:0] d, input logic c,
                         input logic beq, input logic bne, input logic z,
                         input logic [31:0] off);
        @(negedge clk);
        #1;
        InstrValid   = v;
        InstrData    = d;
        Consume      = c;
        BranchEQ     = beq;
        BranchNE     = bne;
        Zero         = z;
        BranchOffset = off;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Reset held over a couple of edges, then released away from the edge.
    task automatic doReset();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;
        settle();
        settle();
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // From FETCH: memory answers at once, unit moves to ISSUE.
    task automatic fetchOne(input logic [31:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        settle();
    endtask

    // From ISSUE: consume with the given branch resolution inputs.
    task automatic retireOne(input logic beq, input logic bne, input logic z, input logic [31:0] off);
        drive(1'b0, 32'd0, 1'b1, beq, bne, z, off);
        settle();
    endtask

    logic [31:0] addrLog[$];

    initial begin
        reset        = 1'b0;
        InstrValid   = 1'b0;
        InstrData    = 32'd0;
        Consume      = 1'b0;
        BranchEQ     = 1'b0;
        BranchNE     = 1'b0;
        Zero         = 1'b0;
        BranchOffset = 32'd0;

        // Reset hold: the compare process verifies the reset values.
        settle();
        settle();
        checkEn = 1'b1;
        settle();

        // First request right after release, InstrValid tied high.
        @(negedge clk);
        #1;
        InstrValid = 1'b1;
        InstrData  = 32'hAC01_2345;       // OP = 0x2B (SW)
        reset      = 1'b1;
        #1;
        chk("first_req",  {31'd0, InstrReq}, 32'd1);
        chk("first_addr", InstrAddr,         32'h0040_0000);
        settle();
        chk("first_ready", {31'd0, InstrReady}, 32'd1);
        chk("first_op",    {26'd0, OP},         32'h0000_002B);

        // Straight-line run: InstrValid and Consume tied high for 6 cycles.
        doReset();
        addrLog.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h2000_0000 + i, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
            if (InstrReq) addrLog.push_back(InstrAddr);
            settle();
        end
        chk("straight_cnt",   addrLog.size(), 32'd3);
        chk("straight_addr0", (addrLog.size() > 0) ? addrLog[0] : 32'hDEAD_BEEF, 32'h0040_0000);
        chk("straight_addr1", (addrLog.size() > 1) ? addrLog[1] : 32'hDEAD_BEEF, 32'h0040_0004);
        chk("straight_addr2", (addrLog.size() > 2) ? addrLog[2] : 32'hDEAD_BEEF, 32'h0040_0008);
        chk("straight_retire", RetireCount, 32'd3);

        // Memory wait states: InstrValid arrives after three idle cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
            settle();
            chk("wait_req",   {31'd0, InstrReq},   32'd1);
            chk("wait_addr",  InstrAddr,           32'h0040_000C);
            chk("wait_ready", {31'd0, InstrReady}, 32'd0);
            chk("wait_retire", RetireCount,        32'd3);
        end
        fetchOne(32'h1000_0000);          // BEQ word
        chk("wait_done_ready", {31'd0, InstrReady}, 32'd1);

        // Now at 0x0040_000C in ISSUE; step to 0x0040_0010.
        retireOne(1'b0, 1'b0, 1'b0, 32'd0);
        fetchOne(32'h1000_FFFE);
        chk("beq_pc", PC, 32'h0040_0010);
        retireOne(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("beq_taken", InstrAddr, 32'h0040_000C);
        fetchOne(32'h0000_0020);
        retireOne(1'b0, 1'b0, 1'b0, 32'd0);
        fetchOne(32'h1000_FFFE);
        retireOne(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
        chk("beq_not_taken", InstrAddr, 32'h0040_0014);

        // Walk to 0x0040_0020 then exercise BNE.
        for (int i = 0; i < 3; i++) begin
            fetchOne(32'h0000_0020);
            retireOne(1'b0, 1'b0, 1'b0, 32'd0);
        end
        fetchOne(32'h1400_0004);
        chk("bne_pc", PC, 32'h0040_0020);
        retireOne(1'b0, 1'b1, 1'b1, 32'd4);
        chk("bne_not_taken", InstrAddr, 32'h0040_0024);
        fetchOne(32'h1000_FFFE);
        retireOne(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);   // back to 0x20
        fetchOne(32'h1400_0004);
        retireOne(1'b0, 1'b1, 1'b0, 32'd4);
        chk("bne_taken", InstrAddr, 32'h0040_0034);

        // Stray InstrValid in ISSUE and Consume in FETCH change nothing.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        settle();
        chk("fetch_consume_pc", PC, 32'h0040_0034);
        fetchOne(32'h8C00_0001);
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        settle();
        chk("stray_valid_instr", Instruction, 32'h8C00_0001);

        // Reset mid-ISSUE: outputs fall without a clock edge.
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_issue_ready",  {31'd0, InstrReady}, 32'd0);
        chk("rst_issue_req",    {31'd0, InstrReq},   32'd0);
        chk("rst_issue_pc",     PC,                  32'h0040_0000);
        chk("rst_issue_retire", RetireCount,         32'd0);
        #1;
        reset = 1'b1;

        // Reset mid-FETCH (memory stalled).
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        settle();
        fetchOne(32'h0);
        retireOne(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_fetch_req",    {31'd0, InstrReq}, 32'd0);
        chk("rst_fetch_pc",     PC,                32'h0040_0000);
        chk("rst_fetch_retire", RetireCount,       32'd0);
        #1;
        reset = 1'b1;

        // Randomized run with occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 55,
                  $urandom,
                  $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32));
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                #1;
                chk("rnd_rst_req",   {31'd0, InstrReq},   32'd0);
                chk("rnd_rst_ready", {31'd0, InstrReady}, 32'd0);
                #1;
                reset = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
